// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
// Build option: PC_MISALIGN_TRAP_EN (trap on misaligned jump/branch targets).
package pc_pkg;

    typedef enum logic [1:0] {
        CTRL_TRANSFER_NONE   = 2'd0,
        CTRL_TRANSFER_JUMP   = 2'd1,
        CTRL_TRANSFER_BRANCH = 2'd2
    } ctrl_transfer_e;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_e;

    localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

    function automatic logic pc_misaligned(input logic [1:0] lsb);
        return (lsb & PC_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/pc_redirect_sel.sv
// Priority redirect select: trap > jump > taken branch.
// Build option: PC_MISALIGN_TRAP_EN selects trap-on-misalign vs force-align.
module pc_redirect_sel
    import pc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      ctrl_transfer_instr_i,
    input  logic [XLEN-1:0] ctrl_pc_i,
    input  logic [XLEN-1:0] offset_i,
    input  logic            branch_tkn_i,
    input  logic [XLEN-1:0] tgt_addr_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] target_o,
`ifdef PC_MISALIGN_TRAP_EN
    output logic [XLEN-1:0] raw_tgt_o,
`endif
    output logic            misalign_o
);

    ctrl_transfer_e  ctrl;
    logic [XLEN-1:0] br_tgt;
    logic [XLEN-1:0] raw_tgt;
    logic            is_cf;

    assign ctrl   = ctrl_transfer_e'(ctrl_transfer_instr_i);
    assign br_tgt = ctrl_pc_i + offset_i;

    always_comb begin
        redirect_o = 1'b0;
        target_o   = '0;
        misalign_o = 1'b0;
        raw_tgt    = '0;
        is_cf      = 1'b0;
        priority case (1'b1)
            trap_i: begin
                redirect_o = 1'b1;
                target_o   = trap_vec_i;
            end
            (ctrl == CTRL_TRANSFER_JUMP): begin
                is_cf   = 1'b1;
                raw_tgt = tgt_addr_i;
            end
            (ctrl == CTRL_TRANSFER_BRANCH) && branch_tkn_i: begin
                is_cf   = 1'b1;
                raw_tgt = br_tgt;
            end
            default: ;
        endcase
        if (is_cf) begin
            redirect_o = 1'b1;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_o = pc_misaligned(raw_tgt[1:0]);
            target_o   = misalign_o ? trap_vec_i : raw_tgt;
`else
            target_o   = raw_tgt & ~XLEN'(PC_ALIGN_MASK);
`endif
        end
    end

`ifdef PC_MISALIGN_TRAP_EN
    assign raw_tgt_o = raw_tgt;
`endif

endmodule

// File: rtl/pc_gen.sv
// Fetch-address generator: BOOT/RUN/HALT FSM, valid/ready issue, redirects.
// Build option: PC_MISALIGN_TRAP_EN enables misaligned-target trapping.
module pc_gen
    import pc_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int              ILEN      = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      ctrl_transfer_instr_i,
    input  logic [XLEN-1:0] ctrl_pc_i,
    input  logic [XLEN-1:0] offset_i,
    input  logic            branch_tkn_i,
    input  logic [XLEN-1:0] tgt_addr_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            halt_i,
    input  logic            pc_ready_i,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic            redirect_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    localparam logic [XLEN-1:0] ILEN_W = XLEN'(ILEN);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            redirect_q, redirect_d;
    logic            sel_redirect;
    logic [XLEN-1:0] sel_target;
    logic            sel_misalign;
    logic            accept;

`ifdef PC_MISALIGN_TRAP_EN
    logic [XLEN-1:0] sel_raw;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
`endif

    pc_redirect_sel #(
        .XLEN (XLEN)
    ) u_sel (
        .ctrl_transfer_instr_i (ctrl_transfer_instr_i),
        .ctrl_pc_i             (ctrl_pc_i),
        .offset_i              (offset_i),
        .branch_tkn_i          (branch_tkn_i),
        .tgt_addr_i            (tgt_addr_i),
        .trap_i                (trap_i),
        .trap_vec_i            (trap_vec_i),
        .redirect_o            (sel_redirect),
        .target_o              (sel_target),
`ifdef PC_MISALIGN_TRAP_EN
        .raw_tgt_o             (sel_raw),
`endif
        .misalign_o            (sel_misalign)
    );

    always_comb begin
        pc_valid_o = (state_q == PC_RUN) && !halt_i;
        accept     = pc_valid_o && pc_ready_i;
        state_d    = state_q;
        pc_d       = pc_q;
        redirect_d = sel_redirect;
        unique case (state_q)
            PC_BOOT: state_d = PC_RUN;
            PC_RUN: begin
                if (halt_i && !sel_redirect) state_d = PC_HALT;
            end
            PC_HALT: begin
                if (trap_i || !halt_i) state_d = PC_RUN;
            end
            default: state_d = PC_BOOT;
        endcase
        // Redirect beats the valid/ready hold and any increment.
        if (sel_redirect)
            pc_d = sel_target;
        else if (accept)
            pc_d = pc_q + ILEN_W;
    end

`ifdef PC_MISALIGN_TRAP_EN
    always_comb begin
        misalign_d      = sel_misalign;
        misalign_addr_d = misalign_addr_q;
        if (sel_misalign) misalign_addr_d = sel_raw;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= PC_BOOT;
            pc_q       <= RESET_VEC;
            redirect_q <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            redirect_q <= redirect_d;
`ifdef PC_MISALIGN_TRAP_EN
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
`endif
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + ILEN_W;
    assign redirect_o = redirect_q;

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;
`else
    logic unused_misalign;
    assign unused_misalign = sel_misalign;
    assign misalign_o      = 1'b0;
    assign misalign_addr_o = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen with RESET_VEC='h100.
// Honours PC_MISALIGN_TRAP_EN for the misaligned-jump expectations.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  ctrl;
    logic [31:0] ctrl_pc, offset, tgt, trap_vec;
    logic        tkn, trap, halt, ready;
    logic        valid, redirect, misalign;
    logic [31:0] pc, pc4, mis_addr;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (32'h100),
        .ILEN      (4)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .ctrl_transfer_instr_i (ctrl),
        .ctrl_pc_i             (ctrl_pc),
        .offset_i              (offset),
        .branch_tkn_i          (tkn),
        .tgt_addr_i            (tgt),
        .trap_i                (trap),
        .trap_vec_i            (trap_vec),
        .halt_i                (halt),
        .pc_ready_i            (ready),
        .pc_valid_o            (valid),
        .pc_o                  (pc),
        .pc_plus4_o            (pc4),
        .redirect_o            (redirect),
        .misalign_o            (misalign),
        .misalign_addr_o       (mis_addr)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; ctrl = 2'd0; ctrl_pc = '0; offset = '0; tgt = '0;
        trap_vec = 32'h40; tkn = 0; trap = 0; halt = 0; ready = 1;
        tick(); tick();
        chk("rst_pc", pc, 32'h100);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_redirect", 32'(redirect), 0);
        chk("rst_misalign", 32'(misalign), 0);
        chk("rst_mis_addr", mis_addr, 0);

        // Test 1: boot then three accepted fetches
        rst_n = 1;
        #1 chk("boot_valid", 32'(valid), 0);
        tick();
        chk("run_valid", 32'(valid), 1);
        chk("t1_pc0", pc, 32'h100);
        chk("t1_plus4", pc4, 32'h104);
        tick(); chk("t1_pc1", pc, 32'h104);
        tick(); chk("t1_pc2", pc, 32'h108);

        // Test 2: jump to 0x200 then stall
        ctrl = 2'd1; tgt = 32'h200;
        tick();
        chk("t2_jpc", pc, 32'h200);
        chk("t2_jredir", 32'(redirect), 1);
        ctrl = 2'd0; ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_hold_pc", pc, 32'h200);
            chk("t2_hold_valid", 32'(valid), 1);
        end
        ready = 1;
        tick(); chk("t2_resume", pc, 32'h204);

        // Test 3: taken branch, then not-taken
        ctrl = 2'd2; ctrl_pc = 32'h300; offset = 32'hFFFF_FFF8; tkn = 1;
        tick();
        chk("t3_br_pc", pc, 32'h2F8);
        chk("t3_br_redir", 32'(redirect), 1);
        ctrl = 2'd0;
        tick();
        chk("t3_seq_pc", pc, 32'h2FC);
        chk("t3_redir_1cyc", 32'(redirect), 0);
        ctrl = 2'd2; tkn = 0;
        tick();
        chk("t3_nt_pc", pc, 32'h300);
        chk("t3_nt_redir", 32'(redirect), 0);
        ctrl = 2'd0;

        // Halt, jump while halted, then trap out of halt
        halt = 1;
        #1 chk("halt_valid_comb", 32'(valid), 0);
        tick(); chk("halt_pc", pc, 32'h300);
        ctrl = 2'd1; tgt = 32'h500;
        tick();
        chk("halt_jpc", pc, 32'h500);
        chk("halt_jredir", 32'(redirect), 1);
        chk("halt_jvalid", 32'(valid), 0);
        // Test 4: trap beats jump and exits halt
        trap = 1; trap_vec = 32'h40; tgt = 32'h800;
        tick();
        chk("t4_pc", pc, 32'h40);
        chk("t4_redir", 32'(redirect), 1);
        trap = 0; ctrl = 2'd0; halt = 0; ready = 0;
        #1 chk("t4_run", 32'(valid), 1);

        // Halt/resume re-issues the same address
        halt = 1;
        tick();
        halt = 0;
        #1 chk("hr_still_halt", 32'(valid), 0);
        tick();
        chk("hr_valid", 32'(valid), 1);
        chk("hr_pc", pc, 32'h40);
        ready = 1;

        // Back-to-back redirects
        ctrl = 2'd1; tgt = 32'h600;
        tick(); chk("b2b_pc0", pc, 32'h600);
        tgt = 32'h700;
        tick();
        chk("b2b_pc1", pc, 32'h700);
        chk("b2b_redir", 32'(redirect), 1);

        // Test 5: misaligned jump
        tgt = 32'h1002; trap_vec = 32'h40;
        tick();
`ifdef PC_MISALIGN_TRAP_EN
        chk("t5_pc", pc, 32'h40);
        chk("t5_mis", 32'(misalign), 1);
        chk("t5_mis_addr", mis_addr, 32'h1002);
`else
        chk("t5_pc", pc, 32'h1000);
        chk("t5_mis", 32'(misalign), 0);
        chk("t5_mis_addr", mis_addr, 0);
`endif
        ctrl = 2'd0;
        tick();
        chk("t5_mis_pulse", 32'(misalign), 0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("t5_addr_held", mis_addr, 32'h1002);
`else
        chk("t5_addr_held", mis_addr, 0);
`endif

        // Test 6: wrap at top of address space
        ctrl = 2'd1; tgt = 32'hFFFF_FFFC;
        tick();
        chk("t6_top", pc, 32'hFFFF_FFFC);
        chk("t6_plus4", pc4, 32'h0);
        ctrl = 2'd0;
        tick(); chk("t6_wrap", pc, 32'h0);

        // Reset mid-stall with a pending jump
        ready = 0; ctrl = 2'd1; tgt = 32'h900; rst_n = 0;
        tick();
        chk("rr_pc", pc, 32'h100);
        chk("rr_redir", 32'(redirect), 0);
        chk("rr_valid", 32'(valid), 0);
        rst_n = 1; ctrl = 2'd0;
        tick();
        chk("rr_run_pc", pc, 32'h100);
        chk("rr_run_valid", 32'(valid), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
